dac_sample_feeder: RTL

//  Upstream stage of the SPI DAC output controller. Buffers 12-bit samples from the synth/mixer
//  in a small FIFO and releases exactly one sample per audio-rate tick (22050 Hz from 50 MHz).

---
 rtl/dac_feeder_pkg.sv | 15 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/dac_sample_feeder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dac_feeder_pkg.sv
// Shared state type and default constants for the DAC sample feeder.
package dac_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BUSY
  } feeder_state_t;

  localparam int DEF_SAMPLE_W    = 12;
  localparam int DEF_DEPTH       = 16;
  localparam int DEF_RATE_DIV    = 2268;
  localparam int DEF_REQ_TIMEOUT = 512;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with synchronous active-high reset.
module sync_fifo
  import dac_feeder_pkg::*;
#(
  parameter int W     = DEF_SAMPLE_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   level_q;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is only taken when a pop frees a slot that cycle.
  assign do_pop  = pop_i && (level_q != '0);
  assign do_push = push_i && ((level_q != FULL_LVL) || do_pop);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (do_pop && !do_push) level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/dac_sample_feeder.sv
// Buffers mixer samples and hands one to the SPI DAC controller per audio-rate tick.
module dac_sample_feeder
  import dac_feeder_pkg::*;
#(
  parameter int SAMPLE_W    = DEF_SAMPLE_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int RATE_DIV    = DEF_RATE_DIV,
  parameter int REQ_TIMEOUT = DEF_REQ_TIMEOUT
) (
  input  logic                    clock_50Mhz_i,
  input  logic                    reset_i,
  input  logic                    enable_i,
  input  logic [SAMPLE_W-1:0]     in_sample_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic [SAMPLE_W-1:0]     out_sample_o,
  output logic                    out_send_n_o,
  input  logic                    dac_busy_i,
  output logic [$clog2(DEPTH):0]  fifo_level_o,
  output logic [15:0]             underrun_count_o,
  output logic [7:0]              missed_tick_count_o,
  output logic                    timeout_err_o
);

  localparam int CW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(RATE_DIV - 1);
  localparam int TW = $clog2(REQ_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(REQ_TIMEOUT - 1);

  logic [CW-1:0]       tick_cnt_q, tick_cnt_d;
  logic                tick;
  logic                busy_meta_q, busy_s_q;
  feeder_state_t       state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                send_n_q, send_n_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [15:0]         underrun_q, underrun_d;
  logic [7:0]          missed_q, missed_d;
  logic                timeout_err_q, timeout_err_d;
  logic                fifo_pop, fifo_full, fifo_empty;
  logic [SAMPLE_W-1:0] fifo_head;

  sync_fifo #(
    .W     (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock_50Mhz_i),
    .reset_i (reset_i),
    .push_i  (in_valid_i),
    .data_i  (in_sample_i),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  assign tick = (tick_cnt_q == TICK_LAST);

  always_comb begin
    tick_cnt_d = tick_cnt_q + 1'b1;
    if (!enable_i || tick) tick_cnt_d = '0;
  end

  // The DAC is paced only by the synchronised busy; REQ gives up after the timer expires.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    sample_d      = sample_q;
    underrun_d    = underrun_q;
    missed_d      = missed_q;
    timeout_err_d = timeout_err_q;
    fifo_pop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            sample_d = fifo_head;
            timer_d  = '0;
            state_d  = REQ;
          end else if (underrun_q != 16'hFFFF) begin
            underrun_d = underrun_q + 1'b1;
          end
        end
      end
      REQ: begin
        if (busy_s_q) begin
          state_d = BUSY;
        end else if (timer_q == TIMER_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      BUSY: begin
        if (!busy_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (tick && (state_q != IDLE) && (missed_q != 8'hFF)) missed_d = missed_q + 1'b1;
    send_n_d = (state_d != REQ);
  end

  always_ff @(posedge clock_50Mhz_i) begin
    if (reset_i) begin
      tick_cnt_q    <= '0;
      busy_meta_q   <= 1'b0;
      busy_s_q      <= 1'b0;
      state_q       <= IDLE;
      timer_q       <= '0;
      send_n_q      <= 1'b1;
      sample_q      <= '0;
      underrun_q    <= '0;
      missed_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      busy_meta_q   <= dac_busy_i;
      busy_s_q      <= busy_meta_q;
      state_q       <= state_d;
      timer_q       <= timer_d;
      send_n_q      <= send_n_d;
      sample_q      <= sample_d;
      underrun_q    <= underrun_d;
      missed_q      <= missed_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign in_ready_o          = !fifo_full || fifo_pop;
  assign out_sample_o        = sample_q;
  assign out_send_n_o        = send_n_q;
  assign underrun_count_o    = underrun_q;
  assign missed_tick_count_o = missed_q;
  assign timeout_err_o       = timeout_err_q;

endmodule
